cache_refill_arbiter: RTL and testbench

- Sequences all cache-line traffic between the core's I-cache/D-cache and a single external block-memory port.
- Detects I-cache misses in fetch and D-cache misses in MEM, and serialises them. D-cache misses get priority.
- For each miss it writes back the dirty victim first, then reads the line, then pulses the cache block write-enable.
- Drives the stall requests consumed by the hazard unit.

---
 rtl/cache_arb_pkg.sv | 29 ++
 rtl/sat_counter.sv | 19 +
 rtl/cache_refill_arbiter.sv | 158 +++++++++++++++
 tb/tb_cache_refill_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared state encoding, request-type constants and state-class helpers
// for the cache refill arbiter.
package cache_arb_pkg;

  typedef logic [3:0] t_arb_state;

  localparam t_arb_state S_IDLE      = 4'd0;
  localparam t_arb_state S_D_WB_REQ  = 4'd1;
  localparam t_arb_state S_D_WB_WAIT = 4'd2;
  localparam t_arb_state S_D_RD_REQ  = 4'd3;
  localparam t_arb_state S_D_RD_WAIT = 4'd4;
  localparam t_arb_state S_D_FILL    = 4'd5;
  localparam t_arb_state S_I_RD_REQ  = 4'd6;
  localparam t_arb_state S_I_RD_WAIT = 4'd7;
  localparam t_arb_state S_I_FILL    = 4'd8;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  function automatic logic is_d_state(input t_arb_state s);
    return (s == S_D_WB_REQ) || (s == S_D_WB_WAIT) || (s == S_D_RD_REQ) ||
           (s == S_D_RD_WAIT) || (s == S_D_FILL);
  endfunction

  function automatic logic is_i_state(input t_arb_state s);
    return (s == S_I_RD_REQ) || (s == S_I_RD_WAIT) || (s == S_I_FILL);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      o_count <= '0;
    end else if (i_inc && (o_count != {WIDTH{1'b1}})) begin
      o_count <= o_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cache_refill_arbiter.sv
// Serialises I/D cache line refills (with dirty write-back) onto one
// block-memory port; D-side misses win over I-side misses.
module cache_refill_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned BLOCK_WIDTH = 512,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_icache_hit,
  input  logic                   i_dcache_hit,
  input  logic                   i_dcache_dirty,
  input  logic                   i_mem_access,
  input  logic [ADDR_WIDTH-1:0]  i_addr_i,
  input  logic [ADDR_WIDTH-1:0]  i_addr_d,
  input  logic [ADDR_WIDTH-1:0]  i_addr_wb,
  input  logic [BLOCK_WIDTH-1:0] i_victim_block,
  input  logic                   i_mem_req_ready,
  input  logic                   i_mem_rsp_valid,
  input  logic [BLOCK_WIDTH-1:0] i_mem_rsp_block,
  output logic                   o_mem_req_valid,
  output logic                   o_mem_req_write,
  output logic [ADDR_WIDTH-1:0]  o_mem_req_addr,
  output logic [BLOCK_WIDTH-1:0] o_mem_req_block,
  output logic [BLOCK_WIDTH-1:0] o_data_block,
  output logic                   o_instr_we,
  output logic                   o_dcache_we,
  output logic                   o_stall_i,
  output logic                   o_stall_d,
  output logic [CNT_WIDTH-1:0]   o_imiss_cnt,
  output logic [CNT_WIDTH-1:0]   o_dmiss_cnt
);

  t_arb_state             state, state_n;
  logic                   imiss, dmiss, inc_i, inc_d;
  logic [ADDR_WIDTH-1:0]  lat_addr_i, lat_addr_d, lat_addr_wb;
  logic [ADDR_WIDTH-1:0]  lat_addr_i_n, lat_addr_d_n, lat_addr_wb_n;
  logic [BLOCK_WIDTH-1:0] lat_victim, lat_victim_n;
  logic                   req_valid_n, req_write_n;
  logic [ADDR_WIDTH-1:0]  req_addr_n;
  logic [BLOCK_WIDTH-1:0] req_block_n;
  logic                   rsp_capture;

  assign imiss = ~i_icache_hit;
  assign dmiss = i_mem_access & ~i_dcache_hit;

  assign o_stall_d = dmiss | is_d_state(state);
  assign o_stall_i = imiss | is_i_state(state);

  assign rsp_capture = i_mem_rsp_valid &&
                       ((state == S_D_RD_WAIT) || (state == S_I_RD_WAIT));

  // Next state, miss-counter increments and latched request fields
  always_comb begin
    state_n       = state;
    inc_i         = 1'b0;
    inc_d         = 1'b0;
    lat_addr_i_n  = lat_addr_i;
    lat_addr_d_n  = lat_addr_d;
    lat_addr_wb_n = lat_addr_wb;
    lat_victim_n  = lat_victim;
    req_valid_n   = 1'b0;
    req_write_n   = REQ_READ;
    req_addr_n    = '0;
    req_block_n   = '0;

    case (state)
      S_IDLE: begin
        lat_addr_i_n  = i_addr_i;
        lat_addr_d_n  = i_addr_d;
        lat_addr_wb_n = i_addr_wb;
        lat_victim_n  = i_victim_block;
        if (dmiss) begin
          inc_d   = 1'b1;
          state_n = i_dcache_dirty ? S_D_WB_REQ : S_D_RD_REQ;
        end else if (imiss) begin
          inc_i   = 1'b1;
          state_n = S_I_RD_REQ;
        end
      end
      S_D_WB_REQ:  if (i_mem_req_ready) state_n = S_D_WB_WAIT;
      S_D_WB_WAIT: if (i_mem_rsp_valid) state_n = S_D_RD_REQ;
      S_D_RD_REQ:  if (i_mem_req_ready) state_n = S_D_RD_WAIT;
      S_D_RD_WAIT: if (i_mem_rsp_valid) state_n = S_D_FILL;
      S_D_FILL:    state_n = S_IDLE;
      S_I_RD_REQ:  if (i_mem_req_ready) state_n = S_I_RD_WAIT;
      S_I_RD_WAIT: if (i_mem_rsp_valid) state_n = S_I_FILL;
      S_I_FILL:    state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase

    // Request fields follow the state being entered so they register in step
    case (state_n)
      S_D_WB_REQ: begin
        req_valid_n = 1'b1;
        req_write_n = REQ_WRITE;
        req_addr_n  = lat_addr_wb_n;
        req_block_n = lat_victim_n;
      end
      S_D_RD_REQ: begin
        req_valid_n = 1'b1;
        req_addr_n  = lat_addr_d_n;
      end
      S_I_RD_REQ: begin
        req_valid_n = 1'b1;
        req_addr_n  = lat_addr_i_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state           <= S_IDLE;
      lat_addr_i      <= '0;
      lat_addr_d      <= '0;
      lat_addr_wb     <= '0;
      lat_victim      <= '0;
      o_mem_req_valid <= 1'b0;
      o_mem_req_write <= REQ_READ;
      o_mem_req_addr  <= '0;
      o_mem_req_block <= '0;
      o_data_block    <= '0;
      o_instr_we      <= 1'b0;
      o_dcache_we     <= 1'b0;
    end else begin
      state           <= state_n;
      lat_addr_i      <= lat_addr_i_n;
      lat_addr_d      <= lat_addr_d_n;
      lat_addr_wb     <= lat_addr_wb_n;
      lat_victim      <= lat_victim_n;
      o_mem_req_valid <= req_valid_n;
      o_mem_req_write <= req_write_n;
      o_mem_req_addr  <= req_addr_n;
      o_mem_req_block <= req_block_n;
      o_instr_we      <= (state_n == S_I_FILL);
      o_dcache_we     <= (state_n == S_D_FILL);
      if (rsp_capture) o_data_block <= i_mem_rsp_block;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_imiss_cnt (
    .i_clk   (i_clk),
    .i_arst  (i_arst),
    .i_inc   (inc_i),
    .o_count (o_imiss_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_dmiss_cnt (
    .i_clk   (i_clk),
    .i_arst  (i_arst),
    .i_inc   (inc_d),
    .o_count (o_dmiss_cnt)
  );

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter with 4-bit miss counters.
module tb_cache_refill_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned BW = 512;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          icache_hit, dcache_hit, dcache_dirty, mem_access;
  logic [AW-1:0] addr_i, addr_d, addr_wb;
  logic [BW-1:0] victim, rsp_block;
  logic          req_ready, rsp_valid;
  logic          req_valid, req_write, instr_we, dcache_we, stall_i, stall_d;
  logic [AW-1:0] req_addr;
  logic [BW-1:0] req_block, data_block;
  logic [CW-1:0] imiss_cnt, dmiss_cnt;

  int checks   = 0;
  int failures = 0;

  logic [BW-1:0] blk_a, blk_b, blk_c, blk_v, blk_d, blk_e, blk_f;

  cache_refill_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .CNT_WIDTH(CW)) dut (
    .i_clk           (clk),
    .i_arst          (rst_n),
    .i_icache_hit    (icache_hit),
    .i_dcache_hit    (dcache_hit),
    .i_dcache_dirty  (dcache_dirty),
    .i_mem_access    (mem_access),
    .i_addr_i        (addr_i),
    .i_addr_d        (addr_d),
    .i_addr_wb       (addr_wb),
    .i_victim_block  (victim),
    .i_mem_req_ready (req_ready),
    .i_mem_rsp_valid (rsp_valid),
    .i_mem_rsp_block (rsp_block),
    .o_mem_req_valid (req_valid),
    .o_mem_req_write (req_write),
    .o_mem_req_addr  (req_addr),
    .o_mem_req_block (req_block),
    .o_data_block    (data_block),
    .o_instr_we      (instr_we),
    .o_dcache_we     (dcache_we),
    .o_stall_i       (stall_i),
    .o_stall_d       (stall_d),
    .o_imiss_cnt     (imiss_cnt),
    .o_dmiss_cnt     (dmiss_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits for a request, checks its fields, handshakes it and returns the response pulse
  task automatic do_req(input string tag, input logic wr, input logic [AW-1:0] addr,
                        input logic [BW-1:0] blk, input int ready_dly, input int rsp_dly,
                        input logic [BW-1:0] rblk);
    int n = 0;
    while (!req_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_valid"}, BW'(req_valid), BW'(1));
    check({tag, "_write"}, BW'(req_write), BW'(wr));
    check({tag, "_addr"}, BW'(req_addr), BW'(addr));
    check({tag, "_block"}, req_block, blk);
    for (int i = 0; i < ready_dly; i++) begin
      step();
      check({tag, "_hold_valid"}, BW'(req_valid), BW'(1));
      check({tag, "_hold_addr"}, BW'(req_addr), BW'(addr));
      check({tag, "_hold_write"}, BW'(req_write), BW'(wr));
    end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    check({tag, "_after_hs"}, BW'(req_valid), BW'(0));
    repeat (rsp_dly) step();
    rsp_valid = 1'b1;
    rsp_block = rblk;
    step();
    rsp_valid = 1'b0;
  endtask

  initial begin
    blk_a = {16{32'hA5A5_0001}};
    blk_b = {16{32'hB0B0_0002}};
    blk_c = {16{32'hC3C3_0003}};
    blk_v = {16{32'hDEAD_BEEF}};
    blk_d = {16{32'hD1D1_0004}};
    blk_e = {16{32'hE2E2_0005}};
    blk_f = {16{32'hF00D_0006}};

    rst_n = 1'b0;
    icache_hit = 1'b1; dcache_hit = 1'b1; dcache_dirty = 1'b0; mem_access = 1'b0;
    addr_i = '0; addr_d = '0; addr_wb = '0; victim = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_block = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", BW'(req_valid), BW'(0));
    check("rst_data", data_block, '0);
    check("rst_stall_i", BW'(stall_i), BW'(0));
    check("rst_cnt_i", BW'(imiss_cnt), BW'(0));
    rst_n = 1'b1;
    step();

    // I-cache miss
    icache_hit = 1'b0; addr_i = 64'h1000;
    #1;
    check("imiss_stall_comb", BW'(stall_i), BW'(1));
    do_req("imiss", 1'b0, 64'h1000, '0, 0, 2, blk_a);
    check("imiss_we", BW'(instr_we), BW'(1));
    check("imiss_dwe", BW'(dcache_we), BW'(0));
    check("imiss_data", data_block, blk_a);
    check("imiss_stall_fill", BW'(stall_i), BW'(1));
    check("imiss_cnt", BW'(imiss_cnt), BW'(1));
    icache_hit = 1'b1;
    step();
    check("imiss_we_off", BW'(instr_we), BW'(0));
    check("imiss_stall_off", BW'(stall_i), BW'(0));

    // Clean D miss
    mem_access = 1'b1; dcache_hit = 1'b0; dcache_dirty = 1'b0; addr_d = 64'h2040;
    #1;
    check("dclean_stall_comb", BW'(stall_d), BW'(1));
    do_req("dclean", 1'b0, 64'h2040, '0, 0, 1, blk_b);
    check("dclean_we", BW'(dcache_we), BW'(1));
    check("dclean_iwe", BW'(instr_we), BW'(0));
    check("dclean_data", data_block, blk_b);
    check("dclean_stall_fill", BW'(stall_d), BW'(1));
    dcache_hit = 1'b1;
    step();
    check("dclean_we_off", BW'(dcache_we), BW'(0));
    check("dclean_stall_off", BW'(stall_d), BW'(0));
    check("dclean_cnt", BW'(dmiss_cnt), BW'(1));

    // Dirty D miss: write-back then refill; refill address is the latched one
    dcache_hit = 1'b0; dcache_dirty = 1'b1; addr_wb = 64'h3000; addr_d = 64'h4000; victim = blk_v;
    do_req("dwb", 1'b1, 64'h3000, blk_v, 0, 1, '0);
    check("dwb_no_we", BW'(dcache_we), BW'(0));
    addr_d = 64'hBAD0; victim = '0; dcache_dirty = 1'b0;
    do_req("drd", 1'b0, 64'h4000, '0, 0, 0, blk_c);
    check("ddirty_we", BW'(dcache_we), BW'(1));
    check("ddirty_data", data_block, blk_c);
    dcache_hit = 1'b1;
    step();
    check("ddirty_cnt", BW'(dmiss_cnt), BW'(2));
    check("ddirty_stall_off", BW'(stall_d), BW'(0));

    // Simultaneous I and D miss: D first, one IDLE cycle, then I
    icache_hit = 1'b0; dcache_hit = 1'b0; addr_d = 64'h5000; addr_i = 64'h6000;
    do_req("both_d", 1'b0, 64'h5000, '0, 0, 0, blk_d);
    check("both_dwe", BW'(dcache_we), BW'(1));
    check("both_istall_dfill", BW'(stall_i), BW'(1));
    check("both_icnt_mid", BW'(imiss_cnt), BW'(1));
    dcache_hit = 1'b1;
    step();
    check("both_idle_valid", BW'(req_valid), BW'(0));
    check("both_idle_stall_d", BW'(stall_d), BW'(0));
    check("both_idle_stall_i", BW'(stall_i), BW'(1));
    do_req("both_i", 1'b0, 64'h6000, '0, 0, 0, blk_e);
    check("both_iwe", BW'(instr_we), BW'(1));
    check("both_idata", data_block, blk_e);
    icache_hit = 1'b1;
    step();
    check("both_icnt", BW'(imiss_cnt), BW'(2));
    check("both_dcnt", BW'(dmiss_cnt), BW'(3));

    // Memory back-pressure: ready low for 5 cycles
    icache_hit = 1'b0; addr_i = 64'h7000;
    do_req("stall5", 1'b0, 64'h7000, '0, 5, 0, blk_f);
    check("stall5_we", BW'(instr_we), BW'(1));
    icache_hit = 1'b1;
    step();
    check("stall5_cnt", BW'(imiss_cnt), BW'(3));

    // Reset during D_RD_WAIT, then a late response must be ignored
    mem_access = 1'b1; dcache_hit = 1'b0; addr_d = 64'h8000;
    step();
    check("rstw_req", BW'(req_valid), BW'(1));
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("rstw_valid", BW'(req_valid), BW'(0));
    check("rstw_dcnt", BW'(dmiss_cnt), BW'(0));
    check("rstw_icnt", BW'(imiss_cnt), BW'(0));
    check("rstw_data", data_block, '0);
    mem_access = 1'b0; dcache_hit = 1'b1;
    step();
    rst_n = 1'b1;
    rsp_valid = 1'b1; rsp_block = blk_a;
    step();
    rsp_valid = 1'b0;
    check("rstw_late_we", BW'(dcache_we), BW'(0));
    check("rstw_late_data", data_block, '0);
    step();
    check("rstw_late_we2", BW'(dcache_we), BW'(0));
    check("rstw_late_valid", BW'(req_valid), BW'(0));

    // 17 I misses against a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      icache_hit = 1'b0;
      addr_i = 64'h10000 + AW'(i) * 64'd64;
      do_req("sat", 1'b0, addr_i, '0, 0, 0, blk_b);
      icache_hit = 1'b1;
      step();
      check("sat_cnt", BW'(imiss_cnt), BW'((i + 1 > 15) ? 15 : i + 1));
    end
    check("sat_final", BW'(imiss_cnt), BW'(15));
    check("sat_dcnt", BW'(dmiss_cnt), BW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
